load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator-side controller that issues RISC-V loads and stores to the word-addressed `datamemory` array. It converts byte-addressed LB/LH/LW/LD/LBU/LHU/LWU/SB/SH/SW/SD requests into whole-word memory reads and writes. Sub-word stores use read-modify-write. Loads are sign- or zero-extended. The block sits between the execute stage and data memory, with a req/ready/done handshake toward the core.

## Interface
- `SIZE`, 64: memory word width in bits. Only 64 is supported.
- `N`, 32: number of memory words. Memory index width is `$clog2(N)`.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `req`  in  1  request valid; accepted on a rising edge where `req && ready`.
- `is_store`  in  1  1 = store, 0 = load; sampled at accept.
- `funct3`  in  3  RISC-V funct3; sampled at accept.
- `addr`  in  64  byte address; sampled at accept.
- `wdata`  in  64  store data, LSB-aligned; sampled at accept.
- `ready`  out  1  high only in IDLE.
- `done`  out  1  one-cycle pulse marking request completion.
- `err`  out  1  valid with `done`; high for a misaligned access or an illegal funct3.
- `rdata`  out  64  load result, valid while `done` is high.
- `MEM_ADDR`  out  `$clog2(N)`  word index to memory.
- `MEM_WE`  out  1  memory write enable.
- `MEM_D_in`  out  64  word written to memory.
- `MEM_D_out`  in  64  combinational read data from memory.

## Operation
- **Address decode:**
  - word index = `addr[3+$clog2(N)-1:3]`; byte offset `off` = `addr[2:0]`.
  - Higher address bits are ignored, so addresses alias modulo 8·N bytes.
- **Byte order:** little-endian; byte k occupies bits [8k+7:8k].
- **Load funct3:** 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU. 111 is illegal.
- **Store funct3:** 000 SB, 001 SH, 010 SW, 011 SD. 1xx is illegal.
- **Alignment:** required, otherwise `err`.
  - Half: `off[0]` must be 0.
  - Word: `off[1:0]` must be 0.
  - Double: `off` must be 0.
- **FSM states:** IDLE, READ, WRITE, RESP.
  - IDLE → RESP: accept with an error condition; no memory write.
  - IDLE → READ: load, or sub-word store (SB/SH/SW).
  - IDLE → WRITE: SD.
  - READ → RESP: load. Capture and extract the lane from `MEM_D_out`.
  - READ → WRITE: sub-word store. Capture the old word and merge the store bytes into lane `off`.
  - WRITE → RESP: `MEM_WE=1` for exactly this one cycle, with `MEM_D_in` = merged word (or `wdata` for SD).
  - RESP → IDLE: `done=1`.
- **Load extraction:** the lane at `off` is sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU) to 64 bits. LD returns the full word.
- **Store merge:** bytes outside the written lane equal the word read in READ.
- **Memory-side outputs:**
  - `MEM_ADDR` holds the captured index in READ and WRITE; it is 0 in IDLE.
  - `MEM_D_in` is 0 outside WRITE.
- **Error responses:** `rdata=0`, memory untouched.
- **Request timing:** `req` is ignored while `ready=0`; requests are not queued.

## Timing
- **Reset values:** state IDLE; `ready=1`, `done=0`, `err=0`, `rdata=0`, `MEM_WE=0`, `MEM_ADDR=0`, `MEM_D_in=0`.
- **Latency,** counted from the accepting edge E (the cycle before the `done` pulse is the last non-IDLE state):
  - Load: `done` is high in the cycle starting at E+2 (IDLE→READ→RESP).
  - Sub-word store: `done` at E+3. `MEM_WE` is high during the cycle starting at E+2; the memory updates at edge E+3.
  - SD: `done` at E+2. `MEM_WE` is high in the cycle starting at E+1.
  - Error: `done` and `err` at E+1.
- **Throughput:** `ready` returns high the cycle after RESP. A new request can be accepted on the edge that ends RESP+1, i.e. there is no back-to-back accept during RESP.
- **Outputs:** `rdata` and `err` are registered and are cleared to 0 when leaving RESP.
- **Reset mid-operation:**
  - Asserting `RST_N` low forces IDLE immediately and drops `MEM_WE` asynchronously.
  - An in-flight store that has not reached the WRITE edge leaves memory unchanged.
  - No `done` is produced for the aborted request.

## Test plan
- **LD, aligned:** memory word 16 = 730; LD `addr`=128 → `done` at E+2, `rdata`=730, `err`=0.
- **Sign vs. zero extension:**
  - LB `addr`=128 → `rdata`=0xFFFF_FFFF_FFFF_FFDA.
  - LBU `addr`=128 → `rdata`=0xDA.
  - LH `addr`=128 → `rdata`=0x02DA.
- **SB merge:** SB `addr`=129, `wdata`=0x55 → `MEM_WE` for exactly one cycle at index 16, `MEM_D_in`=0x55DA; a following LD at 128 returns 0x55DA. `done` at E+3.
- **SD:** SD `addr`=168, `wdata`=0x1122334455667788 → no READ state, `MEM_WE` at E+1, `done` at E+2; word 21 reads back equal to `wdata`.
- **Errors:**
  - SH `addr`=131 → `done`=`err`=1 at E+1, `MEM_WE` never asserted, `rdata`=0.
  - Load with funct3=111 → same error response.
- **Reset mid-store:** pull `RST_N` low during READ of an SB to word 30 (value 1000) → `MEM_WE` stays 0, word 30 remains 1000, `ready`=1 after release, and the next LD returns 1000.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store controller between the execute stage and the word-addressed
// data memory. Byte-addressed RISC-V loads and stores become whole-word
// memory accesses. Sub-word stores read the old word, merge the new bytes
// into it and write it back. Load lanes are sign- or zero-extended.
module load_store_unit #(
  parameter int SIZE = 64,
  parameter int N    = 32
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 req,
  input  logic                 is_store,
  input  logic [2:0]           funct3,
  input  logic [SIZE-1:0]      addr,
  input  logic [SIZE-1:0]      wdata,
  output logic                 ready,
  output logic                 done,
  output logic                 err,
  output logic [SIZE-1:0]      rdata,
  output logic [$clog2(N)-1:0] MEM_ADDR,
  output logic                 MEM_WE,
  output logic [SIZE-1:0]      MEM_D_in,
  input  logic [SIZE-1:0]      MEM_D_out
);

  localparam int AW = $clog2(N);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t          state, nxt;
  logic [SIZE-1:0] rdata_q;
  logic            err_q;

  // Request fields captured at accept; word_p1 holds wdata, then the merged word
  logic [AW-1:0]   idx_p1;
  logic [2:0]      off_p1;
  logic [2:0]      f3_p1;
  logic            st_p1;
  logic [SIZE-1:0] word_p1;

  logic            acc_err;

  // Address bits above the memory index only alias and are never decoded
  logic            unused_addr_hi;
  assign unused_addr_hi = ^addr[SIZE-1:3+AW];

  // Misalignment for the access size, or a funct3 with no matching instruction
  function automatic logic req_err(input logic st, input logic [2:0] f3,
                                   input logic [2:0] off);
    logic mis;
    logic ill;
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = |off[1:0];
      2'b11:   mis = |off;
      default: mis = 1'b0;
    endcase
    ill = st ? f3[2] : (f3 == 3'b111);
    return mis | ill;
  endfunction

  // Pull the lane at byte offset off out of a word and extend it to 64 bits
  function automatic logic [63:0] extract(input logic [63:0] word,
                                          input logic [2:0] f3,
                                          input logic [2:0] off);
    logic [63:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic signed [63:0] res;
    sh = word >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    w  = sh[31:0];
    case (f3)
      3'b000:  res = b;
      3'b001:  res = h;
      3'b010:  res = w;
      3'b011:  res = word;
      3'b100:  res = {56'd0, sh[7:0]};
      3'b101:  res = {48'd0, sh[15:0]};
      3'b110:  res = {32'd0, sh[31:0]};
      default: res = '0;
    endcase
    return res;
  endfunction

  // Replace the lane at byte offset off in old with the low bytes of data
  function automatic logic [63:0] merge(input logic [63:0] old,
                                        input logic [63:0] data,
                                        input logic [2:0] f3,
                                        input logic [2:0] off);
    logic [63:0] m;
    case (f3[1:0])
      2'b00:   m = 64'h0000_0000_0000_00FF;
      2'b01:   m = 64'h0000_0000_0000_FFFF;
      2'b10:   m = 64'h0000_0000_FFFF_FFFF;
      default: m = '1;
    endcase
    m = m << {off, 3'b000};
    return (old & ~m) | ((data << {off, 3'b000}) & m);
  endfunction

  assign acc_err = req_err(is_store, funct3, addr[2:0]);
  assign rdata   = rdata_q;
  assign err     = err_q;

  // Next-state and memory/handshake outputs; memory signals idle at zero
  always_comb begin
    nxt      = state;
    ready    = 1'b0;
    done     = 1'b0;
    MEM_WE   = 1'b0;
    MEM_ADDR = '0;
    MEM_D_in = '0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          if (acc_err)                            nxt = RESP;
          else if (is_store && funct3 == 3'b011)  nxt = WRITE;
          else                                    nxt = READ;
        end
      end
      READ: begin
        MEM_ADDR = idx_p1;
        nxt      = st_p1 ? WRITE : RESP;
      end
      WRITE: begin
        MEM_ADDR = idx_p1;
        MEM_WE   = 1'b1;
        MEM_D_in = word_p1;
        nxt      = RESP;
      end
      RESP: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // State and response registers; rdata/err live only for the RESP cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        IDLE:    if (req && acc_err) err_q <= 1'b1;
        READ:    if (!st_p1) rdata_q <= extract(MEM_D_out, f3_p1, off_p1);
        RESP: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Request capture at accept, then read-modify-write merge in READ
  always_ff @(posedge CLK) begin
    if (state == IDLE && req) begin
      idx_p1  <= addr[3+AW-1:3];
      off_p1  <= addr[2:0];
      f3_p1   <= funct3;
      st_p1   <= is_store;
      word_p1 <= wdata;
    end else if (state == READ && st_p1) begin
      word_p1 <= merge(MEM_D_out, word_p1, f3_p1, off_p1);
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a table of requests with hand-computed
// results, plus reset-state and reset-during-store sequences. The bench owns
// the data memory array. Latency n counts the accepting edge as edge 1, so
// n is the number of rising edges after which an event is first seen.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        req;
  logic        is_store;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [63:0] rdata;
  logic [4:0]  MEM_ADDR;
  logic        MEM_WE;
  logic [63:0] MEM_D_in;
  logic [63:0] MEM_D_out;

  logic [63:0] mem [32];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] wd;
    logic [63:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
    logic [4:0]  exp_idx;
    logic [63:0] exp_din;
  } vec_t;

  vec_t tv[$];

  load_store_unit #(.SIZE(64), .N(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .req(req), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .ready(ready),
    .done(done), .err(err), .rdata(rdata), .MEM_ADDR(MEM_ADDR),
    .MEM_WE(MEM_WE), .MEM_D_in(MEM_D_in), .MEM_D_out(MEM_D_out)
  );

  always #5 CLK = ~CLK;

  assign MEM_D_out = mem[MEM_ADDR];

  always @(posedge CLK) begin
    if (MEM_WE) mem[MEM_ADDR] <= MEM_D_in;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3,
                              input logic [63:0] a, input logic [63:0] wd,
                              input logic [63:0] exp_rd, input logic exp_err,
                              input int exp_lat, input int exp_we,
                              input logic [4:0] exp_idx,
                              input logic [63:0] exp_din);
    vec_t v;
    v.st = st; v.f3 = f3; v.a = a; v.wd = wd; v.exp_rd = exp_rd;
    v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_we = exp_we;
    v.exp_idx = exp_idx; v.exp_din = exp_din;
    return v;
  endfunction

  task automatic wait_ready(input string name);
    int i;
    @(negedge CLK);
    for (i = 0; i < 10 && !ready; i++) @(negedge CLK);
    chk({name, "_ready"}, 64'(ready), 64'd1);
    chk({name, "_idle_addr"}, 64'(MEM_ADDR), 64'd0);
    chk({name, "_idle_din"}, MEM_D_in, 64'd0);
  endtask

  task automatic issue(input string name, input vec_t v);
    int lat;
    int we;
    logic [63:0] got_rd;
    logic        got_err;
    wait_ready(name);
    req = 1'b1; is_store = v.st; funct3 = v.f3; addr = v.a; wdata = v.wd;
    @(posedge CLK);
    #1;
    req = 1'b0; addr = '0; wdata = '0; funct3 = '0; is_store = 1'b0;
    lat = 0; we = 0; got_rd = '0; got_err = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      if (MEM_WE) begin
        we++;
        chk({name, "_we_idx"}, 64'(MEM_ADDR), 64'(v.exp_idx));
        chk({name, "_we_din"}, MEM_D_in, v.exp_din);
        if (v.exp_we != 0) chk({name, "_we_cycle"}, 64'(n), 64'(v.exp_lat - 1));
      end
      if (done) begin
        lat = n; got_rd = rdata; got_err = err;
        break;
      end
      @(posedge CLK);
      #1;
    end
    chk({name, "_latency"}, 64'(lat), 64'(v.exp_lat));
    chk({name, "_we_count"}, 64'(we), 64'(v.exp_we));
    chk({name, "_rdata"}, got_rd, v.exp_rd);
    chk({name, "_err"}, 64'(got_err), 64'(v.exp_err));
    @(posedge CLK);
    #1;
    chk({name, "_done_pulse"}, 64'(done), 64'd0);
    chk({name, "_err_clear"}, 64'(err), 64'd0);
    chk({name, "_rdata_clear"}, rdata, 64'd0);
  endtask

  initial begin
    RST_N = 1'b0; req = 1'b0; is_store = 1'b0; funct3 = '0;
    addr = '0; wdata = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[16] = 64'd730;
    mem[30] = 64'd1000;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_we", 64'(MEM_WE), 64'd0);
    chk("rst_addr", 64'(MEM_ADDR), 64'd0);
    chk("rst_din", MEM_D_in, 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // word 16 = 0x2DA; word 21 written by SD then patched by SW
    tv.push_back(mk(0, 3'b011, 64'd128, 0, 64'd730, 0, 2, 0, 0, 0));
    tv.push_back(mk(0, 3'b000, 64'd128, 0, 64'hFFFF_FFFF_FFFF_FFDA, 0, 2, 0, 0, 0));
    tv.push_back(mk(0, 3'b100, 64'd128, 0, 64'h0000_0000_0000_00DA, 0, 2, 0, 0, 0));
    tv.push_back(mk(0, 3'b001, 64'd128, 0, 64'h0000_0000_0000_02DA, 0, 2, 0, 0, 0));
    tv.push_back(mk(1, 3'b000, 64'd129, 64'h55, 0, 0, 3, 1, 5'd16, 64'h55DA));
    tv.push_back(mk(0, 3'b011, 64'd128, 0, 64'h55DA, 0, 2, 0, 0, 0));
    tv.push_back(mk(0, 3'b000, 64'd129, 0, 64'h55, 0, 2, 0, 0, 0));
    tv.push_back(mk(1, 3'b011, 64'd168, 64'h1122_3344_5566_7788, 0, 0, 2, 1, 5'd21,
                    64'h1122_3344_5566_7788));
    tv.push_back(mk(0, 3'b011, 64'd168, 0, 64'h1122_3344_5566_7788, 0, 2, 0, 0, 0));
    tv.push_back(mk(0, 3'b000, 64'd168, 0, 64'hFFFF_FFFF_FFFF_FF88, 0, 2, 0, 0, 0));
    tv.push_back(mk(0, 3'b001, 64'd174, 0, 64'h1122, 0, 2, 0, 0, 0));
    tv.push_back(mk(0, 3'b110, 64'd168, 0, 64'h5566_7788, 0, 2, 0, 0, 0));
    tv.push_back(mk(1, 3'b010, 64'd172, 64'hDEAD_BEEF, 0, 0, 3, 1, 5'd21,
                    64'hDEAD_BEEF_5566_7788));
    tv.push_back(mk(0, 3'b010, 64'd172, 0, 64'hFFFF_FFFF_DEAD_BEEF, 0, 2, 0, 0, 0));
    tv.push_back(mk(0, 3'b110, 64'd172, 0, 64'h0000_0000_DEAD_BEEF, 0, 2, 0, 0, 0));
    tv.push_back(mk(0, 3'b101, 64'd174, 0, 64'hDEAD, 0, 2, 0, 0, 0));
    tv.push_back(mk(0, 3'b001, 64'd174, 0, 64'hFFFF_FFFF_FFFF_DEAD, 0, 2, 0, 0, 0));
    // Error responses: misaligned SH, illegal load/store funct3, misaligned LD/LW
    tv.push_back(mk(1, 3'b001, 64'd131, 64'hFFFF, 0, 1, 1, 0, 0, 0));
    tv.push_back(mk(0, 3'b111, 64'd128, 0, 0, 1, 1, 0, 0, 0));
    tv.push_back(mk(1, 3'b100, 64'd128, 64'h99, 0, 1, 1, 0, 0, 0));
    tv.push_back(mk(0, 3'b011, 64'd130, 0, 0, 1, 1, 0, 0, 0));
    tv.push_back(mk(0, 3'b010, 64'd130, 0, 0, 1, 1, 0, 0, 0));
    // Alias (128 + 8*32) and memory untouched by the errors
    tv.push_back(mk(0, 3'b011, 64'd384, 0, 64'h55DA, 0, 2, 0, 0, 0));
    // SB into the top byte; upper wdata bits must not leak
    tv.push_back(mk(1, 3'b000, 64'd135, 64'hFFFF_FFFF_FFFF_FF80, 0, 0, 3, 1, 5'd16,
                    64'h8000_0000_0000_55DA));
    tv.push_back(mk(0, 3'b011, 64'd128, 0, 64'h8000_0000_0000_55DA, 0, 2, 0, 0, 0));
    tv.push_back(mk(0, 3'b001, 64'd130, 0, 64'h0, 0, 2, 0, 0, 0));

    foreach (tv[i]) issue($sformatf("v%0d", i), tv[i]);

    chk("mem21_final", mem[21], 64'hDEAD_BEEF_5566_7788);

    // Reset while an SB to word 30 sits in READ
    wait_ready("rstmid");
    req = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 64'd240; wdata = 64'h77;
    @(posedge CLK);
    #1;
    req = 1'b0; is_store = 1'b0; addr = '0; wdata = '0;
    chk("rstmid_read_addr", 64'(MEM_ADDR), 64'd30);
    RST_N = 1'b0;
    #1;
    chk("rstmid_ready_async", 64'(ready), 64'd1);
    chk("rstmid_we_async", 64'(MEM_WE), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      chk("rstmid_we_hold", 64'(MEM_WE), 64'd0);
      chk("rstmid_no_done", 64'(done), 64'd0);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    chk("rstmid_mem30", mem[30], 64'd1000);
    issue("rstmid_ld", mk(0, 3'b011, 64'd240, 0, 64'd1000, 0, 2, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
